moore_seq_det_param: RTL
========================

// Module: moore_seq_det_param
// PURPOSE
//  Parametrised Moore serial-pattern detector, successor to the fixed-pattern Moore detectors.
//  Pattern width, pattern value and overlap mode are set per instance.
//  Accepts one bit per qualified clock (in_valid); out is a registered Moore output of the match state.
//  Sits behind any 1-bit serial source (UART RX bit stream, sync-word hunt, protocol preamble).
// PARAMETERS
//  PAT_W    4        pattern length in bits, legal 2..16
//  PATTERN  4'b1011  pattern; PATTERN[PAT_W-1] is the first bit received
//  OVERLAP  1        1 = overlapping matches allowed, 0 = detector restarts clean after a match
//  CNT_W    8        match counter width (MATCH_COUNT_EN only), legal 1..32
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in         in   1      serial data bit
//  in_valid   in   1      in is sampled only when high
//  out        out  1      high while FSM is in MATCH state
//  match_cnt  out  CNT_W  saturating match count (MATCH_COUNT_EN only)
//  cnt_sat    out  1      high once match_cnt == all-ones (MATCH_COUNT_EN only)
// BEHAVIOUR
//  - States S0..S(PAT_W): Sk = last k accepted bits equal the first k pattern bits; S(PAT_W) = MATCH.
//    State reg width = $clog2(PAT_W+1), one-hot not required.
//  - Next state (in_valid=1) uses the KMP failure function of PATTERN, evaluated at elaboration by a
//    constant function; no runtime pattern memory.
//    From Sk (k<PAT_W): if in == PATTERN[PAT_W-1-k] -> S(k+1),
//    else -> fall back via the failure chain to the longest proper prefix still consistent with in.
//  - From MATCH: OVERLAP=1 -> behave as S(fail(PAT_W)) with the new bit;
//    OVERLAP=0 -> behave as S0 with the new bit (the new bit may start S1).
//  - in_valid=0: state holds, and out holds; in is ignored.
//  - out = (state == MATCH), a pure function of the state register.
//    High in the cycle after the edge that accepted the last pattern bit (latency 1 clk).
//  - rst=1 at an edge: state <= S0, out <= 0, match_cnt <= 0, cnt_sat <= 0.
//    rst overrides in_valid on the same edge, and aborts any partial match mid-stream.
//  - Any state encoding outside S0..S(PAT_W) returns to S0 on the next edge.
//  - Illegal PAT_W or CNT_W: elaboration-time error via generate-block check.
// CONFIGURATION
//  MATCH_COUNT_EN defined:
//    - match_cnt increments by 1 on each edge where the state enters MATCH (including MATCH->MATCH
//      under OVERLAP); a held MATCH during in_valid=0 does not count.
//    - match_cnt saturates at 2^CNT_W-1; cnt_sat is registered and goes high the same edge
//      match_cnt reaches that value; only rst clears either output.
//  MATCH_COUNT_EN undefined:
//    - match_cnt and cnt_sat ports are absent and no counter logic is built.
//    - The FSM and out are cycle-identical to the defined case.
// TESTING  (PAT_W=4, PATTERN=4'b1011 unless stated; all bits with in_valid=1)
//  1 OVERLAP=1, in=1,0,1,1,0,1,1 -> out high one clk after bit 4 and after bit 7; match_cnt=2.
//  2 OVERLAP=0, same stream -> out high only after bit 4; bit 7 leaves state S1; match_cnt=1.
//  3 in=1,1,0,1,1 (failure-chain check) -> S1,S1,S2,S3,MATCH; out high after bit 5.
//  4 in=1,0,1, then rst=1 for 1 clk with in_valid=1,in=1, then in=1 -> out never high;
//    state=S1 at end; match_cnt=0.
//  5 in=1,0, in_valid=0 for 3 clks (in toggling), then 1,1 -> out high after the 4th valid bit.
//    Then in_valid=0 for 2 clks: out stays high, match_cnt stays 1.
//  6 MATCH_COUNT_EN, CNT_W=2, OVERLAP=1, in=1,0,1,1 repeated 5x -> match_cnt stops at 3.
//    cnt_sat rises on the 3rd match and stays high until rst.

Source files
------------

// File: rtl/moore_seq_det_param.sv
// Parametrised Moore serial-pattern detector driven by a KMP-derived next-state table.
// Optional saturating match counter when MATCH_COUNT_EN is defined.
module moore_seq_det_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  output logic             out
`ifdef MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
`endif
);

  localparam int SW     = $clog2(PAT_W + 1);
  localparam int NSTATE = PAT_W + 1;
  localparam int TBL_W  = 2 * NSTATE * SW;
  localparam int NENC   = 1 << SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t S_IDLE  = '0;
  localparam state_t S_MATCH = state_t'(PAT_W);

  generate
    if (PAT_W < 2 || PAT_W > 16) begin : g_pat_w_check
      $error("moore_seq_det_param: PAT_W must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_cnt_w_check
      $error("moore_seq_det_param: CNT_W must be in 1..32");
    end
  endgenerate

  // Bit i of the pattern in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input int i);
    logic [PAT_W-1:0] t;
    t = PATTERN >> (PAT_W - 1 - i);
    return t[0];
  endfunction

  // Length of the longest proper prefix of the first k pattern bits that is also their suffix.
  function automatic int fail_of(input int k);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l < k; l++) begin
      ok = 1'b1;
      for (int j = 0; j < l; j++) begin
        if (pat_bit(j) != pat_bit(k - l + j)) ok = 1'b0;
      end
      if (ok) best = l;
    end
    return best;
  endfunction

  function automatic int next_of(input int k, input logic b);
    int s;
    if (k == PAT_W) s = OVERLAP ? fail_of(PAT_W) : 0;
    else            s = k;
    for (int it = 0; it < PAT_W; it++) begin
      if (s > 0 && pat_bit(s) != b) s = fail_of(s);
    end
    return (pat_bit(s) == b) ? s + 1 : 0;
  endfunction

  // Entry (2*k + b) holds the successor of state k on input bit b.
  function automatic logic [TBL_W-1:0] build_tbl();
    logic [TBL_W-1:0] t;
    t = '0;
    for (int k = 0; k <= PAT_W; k++) begin
      for (int b = 0; b < 2; b++) begin
        t = t | (TBL_W'(state_t'(next_of(k, b[0]))) << ((2 * k + b) * SW));
      end
    end
    return t;
  endfunction

  function automatic logic [NENC-1:0] build_legal();
    logic [NENC-1:0] m;
    m = '0;
    for (int i = 0; i < NSTATE; i++) m = m | (NENC'(1) << i);
    return m;
  endfunction

  localparam logic [TBL_W-1:0] NEXT_TBL   = build_tbl();
  localparam logic [NENC-1:0]  LEGAL_MASK = build_legal();

  state_t state_q, state_d;
  logic   legal;

  always_comb begin
    legal   = LEGAL_MASK[state_q];
    state_d = state_q;
    if (!legal) begin
      state_d = S_IDLE;
    end else if (in_valid) begin
      state_d = state_t'(NEXT_TBL >> ((2 * int'(state_q) + int'(in)) * SW));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  assign out = (state_q == S_MATCH);

`ifdef MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             cnt_sat_q, cnt_sat_d;
  logic             enter_match;

  // Only a qualified bit can enter MATCH, so a held MATCH never counts twice.
  always_comb begin
    enter_match = in_valid && legal && (state_d == S_MATCH);
    match_cnt_d = match_cnt_q;
    if (enter_match && (match_cnt_q != CNT_MAX)) match_cnt_d = match_cnt_q + CNT_W'(1);
    cnt_sat_d = cnt_sat_q | (match_cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt_q <= '0;
      cnt_sat_q   <= 1'b0;
    end else begin
      match_cnt_q <= match_cnt_d;
      cnt_sat_q   <= cnt_sat_d;
    end
  end

  assign match_cnt = match_cnt_q;
  assign cnt_sat   = cnt_sat_q;
`endif

endmodule
